control_unit_mc: RTL and testbench
==================================

# control_unit_mc

Parametrised multicycle control unit for the lab processor datapath. It sequences fetch, operand load, execute and write-back for one instruction at a time, and drives the register-file enables, bus mux, ALU opcode and immediate. It adds four things over the fixed 8-register sequencer: configurable width and register count, a fetch handshake, back-to-back execution while `run` is held, and move and halt instruction formats.

## Interface
- `DATA_W`, 16: datapath and immediate output width.
- `INST_W`, 16: instruction width.
- `NREG`, 8: number of general registers; power of two, at least 2.
- `RW`, $clog2(NREG): register index width (derived).
- `IMM_SIGNED`, 0: 1 sign-extends the immediate, 0 zero-extends it.
- `ALU_PASS_B`, 3'b111: ALU opcode issued for the move format.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: start, or continue, execution.
- `inst_valid` in 1: instruction memory has data for the pending request.
- `reg_inst` in INST_W: instruction register contents. Valid from the cycle after `en_i`.
- `inst_req` out 1: fetch request.
- `en_i` out 1: load the instruction register.
- `en_s` out 1: load the ALU operand A register.
- `en_c` out 1: load the ALU result register.
- `reg_en` out NREG: one-hot register write enable.
- `mux_select` out RW+1: bus source. {0,idx} selects register idx; {1,0…} selects the immediate.
- `alu_select` out 3: ALU opcode.
- `immediate` out DATA_W: extended immediate.
- `done` out 1: one-cycle pulse at write-back.
- `busy` out 1: an instruction is in flight.
- `halted` out 1: a halt has been executed.

## Operation
- Instruction fields:
  - rd = `reg_inst[INST_W-1 -: RW]`
  - rs = `reg_inst[INST_W-RW-1 -: RW]`
  - imm = `reg_inst[INST_W-RW-1:5]`, which is IMM_W = INST_W-RW-5 bits
  - op = `reg_inst[4:2]`
  - fmt = `reg_inst[1:0]`
- Formats:
  - 00: ALU, rd ← rd op rs.
  - 01: ALU-immediate, rd ← rd op imm.
  - 10: move, rd ← rs, executed with ALU_PASS_B.
  - 11: halt.
- States: IDLE, FETCH, DECODE, LOAD, EXEC, WB, HALT.
- State outputs and transitions:
  - IDLE: all outputs 0. Goes to FETCH when `run`=1.
  - FETCH: `inst_req`=1. When `inst_valid`=1, `en_i`=1 in that same cycle and the next state is DECODE; otherwise stay in FETCH.
  - DECODE: no enables. fmt 11 goes to HALT, any other fmt goes to LOAD.
  - LOAD: `en_s`=1, `mux_select`={0,rd}.
  - EXEC: `en_c`=1.
    - fmt 00: `mux_select`={0,rs}, `alu_select`=op.
    - fmt 01: `mux_select`={1,0}, `alu_select`=op, `immediate`=extend(imm).
    - fmt 10: `mux_select`={0,rs}, `alu_select`=ALU_PASS_B.
  - WB: `reg_en`=1<<rd, `done`=1. Next state is FETCH if `run`=1, else IDLE.
  - HALT: `halted`=1, all other outputs 0. Left only by reset; `run` and `inst_valid` are ignored.
- `busy`=1 in FETCH, DECODE, LOAD, EXEC and WB.
- Outputs are combinational from the state register and `reg_inst`.
- `immediate` is 0 outside EXEC with fmt 01.
- Extension: IMM_W bits are zero- or sign-extended to DATA_W according to `IMM_SIGNED`. If IMM_W > DATA_W, the low DATA_W bits are used.

## Timing
- Reset (`rst_n`=0): state is IDLE immediately, without waiting for a clock edge. All outputs are 0, including `halted`.
- Latency:
  - `run` high at edge k puts the unit in FETCH in cycle k+1.
  - With `inst_valid` already high, WB (`done`) falls 4 cycles after the fetch-accept cycle.
  - Issue rate is one instruction per 5 cycles back-to-back.
- Fetch stall: FETCH holds `inst_req` high indefinitely. Exactly one `en_i` pulse is issued per accepted instruction.
- Dropping `run` mid-instruction does not abort: the instruction completes through WB, then the unit returns to IDLE.
- `run` high in WB: the next cycle is FETCH, with no IDLE cycle in between.
- Reset asserted in any state, including mid-EXEC or HALT, aborts to IDLE. No `reg_en` or `done` is issued for the aborted instruction.
- `reg_en` is exactly one-hot in WB and all-zero in every other state.

## Test plan
- Reset mid-EXEC: assert `rst_n`=0 with the unit in EXEC → all outputs 0 before the next edge; state IDLE after release.
- Register-register op, defaults, `reg_inst`=16'b011_010_00000_001_00 (rd=3, rs=2, op=1, fmt 00) with `run`=1 and `inst_valid` tied 1:
  - `en_i` in cycle 1.
  - `en_s` with `mux_select`=4'b0011 in cycle 3.
  - `en_c` with `mux_select`=4'b0010 and `alu_select`=1 in cycle 4.
  - `reg_en`=8'b00001000 and `done`=1 in cycle 5.
- Immediate op, fmt 01 with imm=8'hF0, checked in EXEC:
  - `IMM_SIGNED`=0 → `immediate`=16'h00F0, `mux_select`=4'b1000.
  - `IMM_SIGNED`=1 → `immediate`=16'hFFF0.
- Fetch stall and back-to-back run:
  - Hold `inst_valid` low for 3 cycles → `inst_req` stays high and `en_i` stays low.
  - Then raise `inst_valid` with `run` held → two moves complete with `done` pulses exactly 5 cycles apart, and `alu_select`=ALU_PASS_B in each EXEC.
- Halt: fmt 11 → `halted`=1 from the cycle after DECODE. A later `run` pulse produces no `inst_req`. Reset clears `halted`.
- Run dropped and NREG=16: deassert `run` during LOAD → WB still occurs, then IDLE. With `NREG`=16 and `INST_W`=16, rd=4'hF gives `reg_en`=16'h8000.

Source files
------------

// File: rtl/control_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_mc
// Description : Multicycle control unit for the lab processor datapath.
//               Executes one instruction at a time in this order:
//               fetch (with handshake), decode, operand load, execute and
//               write-back. Back-to-back instructions issue while run is
//               held high.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               run             - start / continue execution
//               inst_valid      - instruction memory has data for inst_req
//               reg_inst        - instruction register contents
//               inst_req        - fetch request
//               en_i/en_s/en_c  - instruction / operand A / result loads
//               reg_en          - one-hot register-file write enable
//               mux_select      - bus source ({0,idx} reg, {1,0..} immediate)
//               alu_select      - ALU opcode
//               immediate       - extended immediate (EXEC of fmt 01 only)
//               done/busy/halted- status
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit_mc #(
    parameter int          DATA_W     = 16,
    parameter int          INST_W     = 16,
    parameter int          NREG       = 8,
    parameter int          RW         = $clog2(NREG),
    parameter bit          IMM_SIGNED = 1'b0,
    parameter logic [2:0]  ALU_PASS_B = 3'b111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] reg_inst,
    output logic              inst_req,
    output logic              en_i,
    output logic              en_s,
    output logic              en_c,
    output logic [NREG-1:0]   reg_en,
    output logic [RW:0]       mux_select,
    output logic [2:0]        alu_select,
    output logic [DATA_W-1:0] immediate,
    output logic              done,
    output logic              busy,
    output logic              halted
);

    localparam int c_imm_w = INST_W - RW - 5;

    localparam logic [1:0] c_fmt_alu  = 2'b00;
    localparam logic [1:0] c_fmt_imm  = 2'b01;
    localparam logic [1:0] c_fmt_move = 2'b10;
    localparam logic [1:0] c_fmt_halt = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_LOAD   = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;

    // Instruction fields. rs and imm share the same upper bits; the format
    // decides which interpretation is used.
    logic [RW-1:0]       w_rd;
    logic [RW-1:0]       w_rs;
    logic [c_imm_w-1:0]  w_imm;
    logic [2:0]          w_op;
    logic [1:0]          w_fmt;
    logic [DATA_W-1:0]   w_imm_ext;

    assign w_rd  = reg_inst[INST_W-1 -: RW];
    assign w_rs  = reg_inst[INST_W-RW-1 -: RW];
    assign w_imm = reg_inst[INST_W-RW-1:5];
    assign w_op  = reg_inst[4:2];
    assign w_fmt = reg_inst[1:0];

    generate
        if (c_imm_w >= DATA_W) begin : g_imm_trunc
            assign w_imm_ext = w_imm[DATA_W-1:0];
        end else begin : g_imm_extend
            assign w_imm_ext = {{(DATA_W-c_imm_w){IMM_SIGNED & w_imm[c_imm_w-1]}}, w_imm};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_req   = 1'b0;
        en_i       = 1'b0;
        en_s       = 1'b0;
        en_c       = 1'b0;
        reg_en     = '0;
        mux_select = '0;
        alu_select = '0;
        immediate  = '0;
        done       = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                inst_req = 1'b1;
                // Accept in the same cycle the memory responds so exactly
                // one IR load happens per instruction.
                if (inst_valid) begin
                    en_i    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_d = (w_fmt == c_fmt_halt) ? S_HALT : S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                en_s       = 1'b1;
                mux_select = {1'b0, w_rd};
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                en_c    = 1'b1;
                state_d = S_WB;
                case (w_fmt)
                    c_fmt_alu: begin
                        mux_select = {1'b0, w_rs};
                        alu_select = w_op;
                    end
                    c_fmt_imm: begin
                        mux_select = {1'b1, {RW{1'b0}}};
                        alu_select = w_op;
                        immediate  = w_imm_ext;
                    end
                    c_fmt_move: begin
                        mux_select = {1'b0, w_rs};
                        alu_select = ALU_PASS_B;
                    end
                    default: begin
                        // Halt never reaches EXEC.
                    end
                endcase
            end
            S_WB: begin
                busy    = 1'b1;
                reg_en  = NREG'(1) << w_rd;
                done    = 1'b1;
                // Holding run chains straight into the next fetch.
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                // Terminal until reset.
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit_mc
// Description : Directed self-checking bench for control_unit_mc. Three
//               instances: defaults, sign-extended immediate, and 16
//               registers. All share clock, reset, run and inst_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        inst_valid;
    logic [15:0] reg_inst;
    logic [15:0] reg_inst16;

    // Default instance
    logic        inst_req, en_i, en_s, en_c, done, busy, halted;
    logic [7:0]  reg_en;
    logic [3:0]  mux_select;
    logic [2:0]  alu_select;
    logic [15:0] immediate;

    // Sign-extending instance
    logic        s_inst_req, s_en_i, s_en_s, s_en_c, s_done, s_busy, s_halted;
    logic [7:0]  s_reg_en;
    logic [3:0]  s_mux_select;
    logic [2:0]  s_alu_select;
    logic [15:0] s_immediate;

    // 16-register instance
    logic        w_inst_req, w_en_i, w_en_s, w_en_c, w_done, w_busy, w_halted;
    logic [15:0] w_reg_en;
    logic [4:0]  w_mux_select;
    logic [2:0]  w_alu_select;
    logic [15:0] w_immediate;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int done_cyc     = 0;

    wire [37:0] out0 = {inst_req, en_i, en_s, en_c, reg_en, mux_select,
                        alu_select, immediate, done, busy, halted};

    always #5 clk = ~clk;

    control_unit_mc dut (
        .clk(clk), .rst_n(rst_n), .run(run), .inst_valid(inst_valid),
        .reg_inst(reg_inst), .inst_req(inst_req), .en_i(en_i), .en_s(en_s),
        .en_c(en_c), .reg_en(reg_en), .mux_select(mux_select),
        .alu_select(alu_select), .immediate(immediate), .done(done),
        .busy(busy), .halted(halted)
    );

    control_unit_mc #(.IMM_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .run(run), .inst_valid(inst_valid),
        .reg_inst(reg_inst), .inst_req(s_inst_req), .en_i(s_en_i),
        .en_s(s_en_s), .en_c(s_en_c), .reg_en(s_reg_en),
        .mux_select(s_mux_select), .alu_select(s_alu_select),
        .immediate(s_immediate), .done(s_done), .busy(s_busy),
        .halted(s_halted)
    );

    control_unit_mc #(.NREG(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run), .inst_valid(inst_valid),
        .reg_inst(reg_inst16), .inst_req(w_inst_req), .en_i(w_en_i),
        .en_s(w_en_s), .en_c(w_en_c), .reg_en(w_reg_en),
        .mux_select(w_mux_select), .alu_select(w_alu_select),
        .immediate(w_immediate), .done(w_done), .busy(w_busy),
        .halted(w_halted)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_inst(input logic [15:0] v);
        reg_inst   = v;
        reg_inst16 = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        inst_valid = 1'b0;
        set_inst(16'h0000);
        #2;
        chk("reset_outputs", 64'(out0), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- Register-register op: rd=3, rs=2, op=1, fmt 00 ----
        set_inst(16'b011_010_00000_001_00);
        inst_valid = 1'b1;
        run        = 1'b1;
        step();                                   // cycle 1: FETCH
        chk("rr_fetch_en_i", {inst_req, en_i, busy}, 3'b111);
        run = 1'b0;
        step();                                   // cycle 2: DECODE
        chk("rr_decode_quiet", {en_i, en_s, en_c, busy, done}, 5'b00010);
        step();                                   // cycle 3: LOAD
        chk("rr_load", {en_s, mux_select}, {1'b1, 4'b0011});
        step();                                   // cycle 4: EXEC
        chk("rr_exec", {en_c, en_s, mux_select, alu_select, immediate},
            {1'b1, 1'b0, 4'b0010, 3'd1, 16'h0000});
        step();                                   // cycle 5: WB
        chk("rr_wb", {reg_en, done}, {8'b0000_1000, 1'b1});
        step();
        chk("rr_idle_after", 64'(out0), 64'd0);

        // ---- Immediate op: rd=1, imm=8'hF0, op=2, fmt 01 ----
        set_inst(16'h3E09);
        run = 1'b1;
        step();                                   // FETCH
        run = 1'b0;
        step();                                   // DECODE
        step();                                   // LOAD
        chk("imm_load_mux", {en_s, mux_select}, {1'b1, 4'b0001});
        step();                                   // EXEC
        chk("imm_exec_zext", {en_c, mux_select, alu_select, immediate},
            {1'b1, 4'b1000, 3'd2, 16'h00F0});
        chk("imm_exec_sext", {s_en_c, s_mux_select, s_immediate},
            {1'b1, 4'b1000, 16'hFFF0});
        step();                                   // WB
        chk("imm_wb", {reg_en, done, immediate}, {8'b0000_0010, 1'b1, 16'h0000});
        step();
        chk("imm_idle_after", {busy, s_busy}, 2'b00);

        // ---- Fetch stall then two back-to-back moves ----
        inst_valid = 1'b0;
        set_inst(16'b101_110_00000_000_10);       // move r5 <- r6
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_fetch", {inst_req, en_i, busy}, 3'b101);
        end
        inst_valid = 1'b1;
        #1;
        chk("stall_accept", {inst_req, en_i}, 2'b11);
        step();                                   // DECODE
        chk("mv1_decode", {inst_req, en_i}, 2'b00);
        step();                                   // LOAD
        step();                                   // EXEC
        chk("mv1_exec", {en_c, mux_select, alu_select}, {1'b1, 4'b0110, 3'b111});
        step();                                   // WB
        chk("mv1_wb", {reg_en, done}, {8'b0010_0000, 1'b1});
        done_cyc = cyc;
        step();                                   // FETCH, no IDLE gap
        chk("b2b_fetch", {inst_req, en_i, busy}, 3'b111);
        set_inst(16'b000_001_00000_000_10);       // move r0 <- r1
        step();                                   // DECODE
        step();                                   // LOAD
        chk("mv2_load", {en_s, mux_select}, {1'b1, 4'b0000});
        step();                                   // EXEC
        chk("mv2_exec", {en_c, mux_select, alu_select}, {1'b1, 4'b0001, 3'b111});
        run = 1'b0;
        step();                                   // WB
        chk("mv2_wb", {reg_en, done}, {8'b0000_0001, 1'b1});
        chk("b2b_spacing", 64'(cyc - done_cyc), 64'd5);
        step();
        chk("mv_idle_after", 64'(out0), 64'd0);

        // ---- Halt ----
        set_inst(16'h0003);
        run = 1'b1;
        step();                                   // FETCH
        run = 1'b0;
        step();                                   // DECODE
        chk("halt_decode", {halted, busy}, 2'b01);
        step();                                   // HALT
        chk("halt_state", 64'(out0), 64'd1);
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        chk("halt_ignores_run", {inst_req, halted, busy}, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("halt_reset_clears", 64'(out0), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("halt_reset_idle", 64'(out0), 64'd0);

        // ---- Reset in the middle of EXEC ----
        set_inst(16'b011_010_00000_001_00);
        run = 1'b1;
        step();                                   // FETCH
        run = 1'b0;
        step();                                   // DECODE
        step();                                   // LOAD
        step();                                   // EXEC
        chk("rst_mid_exec_pre", {en_c, busy}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_exec_async", 64'(out0), 64'd0);
        step();
        rst_n = 1'b1;
        chk("rst_mid_exec_no_wb", {reg_en, done}, 9'd0);
        step();
        chk("rst_mid_exec_idle", 64'(out0), 64'd0);

        // ---- Run dropped during LOAD; 16-register instance with rd=F ----
        reg_inst   = 16'b011_010_00000_001_00;
        reg_inst16 = 16'hF000;
        run = 1'b1;
        step();                                   // FETCH
        step();                                   // DECODE
        step();                                   // LOAD
        chk("w_load_mux", {w_en_s, w_mux_select}, {1'b1, 5'b01111});
        run = 1'b0;
        step();                                   // EXEC
        step();                                   // WB
        chk("w_wb_reg_en", {w_reg_en, w_done}, {16'h8000, 1'b1});
        chk("drop_run_wb", {reg_en, done}, {8'b0000_1000, 1'b1});
        step();
        chk("drop_run_idle", {busy, w_busy, inst_req, w_inst_req}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
